// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, prefetches ROM words into a small FIFO
// and handles branch redirects. Optional perf counters are enabled by FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int          MEM_SIZE = 1024,
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]  DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [63:0] LAST_OK = 64'(MEM_SIZE - 3);

    typedef enum logic [1:0] {RUN, HALT, ERR} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t                 state, state_n;
    logic   [63:0]          pc;
    entry_t [DEPTH-1:0]     fifo;
    logic   [PW-1:0]        head, tail;
    logic   [PW:0]          count;
    logic                   pop, push, in_range, full;

    // pc < MEM_SIZE-3 is the 64-bit-safe form of pc+3 < MEM_SIZE (no wrap).
    assign in_range  = (pc < LAST_OK);
    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = (state == RUN) & ~redirect & in_range & (~full | pop);

    assign imem_addr    = pc;
    assign out_pc       = fifo[head].pc;
    assign out_instr    = fifo[head].instr;
    assign halted       = (state == HALT);
    assign misalign_err = (state == ERR);

    always_comb begin
        state_n = state;
        if (redirect)
            state_n = (redirect_pc[1:0] == 2'b00) ? RUN : ERR;
        else if (state == RUN && !in_range)
            state_n = HALT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            fifo  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            // Flush wins over any same-cycle pop or push.
            pc    <= redirect_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo[tail] <= '{pc: pc, instr: imem_instr};
                tail       <= tail + PW'(1);
                pc         <= pc + 64'd4;
            end
            if (pop)
                head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic stall_ev, flush_ev;
    assign stall_ev = (state == RUN) & ~redirect & in_range & full & ~pop;
    assign flush_ev = redirect & out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (push && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall_ev && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
            if (flush_ev && perf_flush != 32'hFFFF_FFFF)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected PCs, a negedge
// monitor pops and compares every accepted output word.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_p;

    always #5 clk = ~clk;

    // ROM model: each word encodes its own byte address.
    assign imem_instr = {8'hA5, imem_addr[23:0]};

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pcs(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 64'(4 * i));
    endtask

    // A handshake during a redirect is discarded by the DUT, so it is not consumed here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
            end else begin
                mon_p = exp_q.pop_front();
                check("out_pc", out_pc, mon_p);
                check("out_instr", {32'h0, out_instr}, {32'h0, 8'hA5, mon_p[23:0]});
            end
        end
    end

    initial begin
        reset = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        #3;
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_pc", out_pc, 64'h0);
        check("rst_instr", {32'h0, out_instr}, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h0);
        check("rst_misalign", {63'h0, misalign_err}, 64'h0);

        // Straight line, then async reset between edges
        @(posedge clk); #1; reset = 1'b0;
        expect_pcs(64'h0, 6);
        step(6); #6;
        reset = 1'b1; #1;
        check("arst_valid", {63'h0, out_valid}, 64'h0);
        check("arst_addr", imem_addr, 64'h0);
        check("drain_a", 64'(exp_q.size()), 64'h0);

        // Backpressure
        out_ready = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        step(5);
        check("bp_valid", {63'h0, out_valid}, 64'h1);
        check("bp_addr", imem_addr, 64'h8);
        check("bp_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        expect_pcs(64'h0, 5);
        step(5);
        check("drain_b", 64'(exp_q.size()), 64'h0);

        // Redirect with two buffered entries, one popped in the same cycle
        check("pre_redir_full", {63'h0, out_valid}, 64'h1);
        redirect = 1'b1; redirect_pc = 64'h40;
        step(1); redirect = 1'b0;
        check("redir_valid", {63'h0, out_valid}, 64'h0);
        check("redir_addr", imem_addr, 64'h40);
        expect_pcs(64'h40, 3);
        step(4);
        check("drain_c", 64'(exp_q.size()), 64'h0);

        // End of memory
        redirect = 1'b1; redirect_pc = 64'h3F8;
        step(1); redirect = 1'b0;
        expect_pcs(64'h3F8, 2);
        step(4);
        check("eom_halted", {63'h0, halted}, 64'h1);
        check("eom_valid", {63'h0, out_valid}, 64'h0);
        check("eom_addr", imem_addr, 64'h400);
        check("drain_d", 64'(exp_q.size()), 64'h0);
        step(3);
        check("eom_addr_hold", imem_addr, 64'h400);
        check("eom_valid_hold", {63'h0, out_valid}, 64'h0);

        // Aligned target near 2^64 must be out of range, not wrap
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1); redirect = 1'b0;
        check("wrap_run", {63'h0, halted}, 64'h0);
        step(2);
        check("wrap_halted", {63'h0, halted}, 64'h1);
        check("wrap_valid", {63'h0, out_valid}, 64'h0);
        check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        redirect = 1'b1; redirect_pc = 64'h0;
        exp_q.push_back(64'h0);
        step(1); redirect = 1'b0;
        check("unhalt", {63'h0, halted}, 64'h0);
        step(2);
        check("drain_e", 64'(exp_q.size()), 64'h0);

        // Misaligned redirect
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h42;
        step(1); redirect = 1'b0;
        check("mis_err", {63'h0, misalign_err}, 64'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("mis_novalid", {63'h0, out_valid}, 64'h0);
        end
        check("mis_sticky", {63'h0, misalign_err}, 64'h1);
        redirect = 1'b1; redirect_pc = 64'h44;
        expect_pcs(64'h44, 2);
        step(1); redirect = 1'b0;
        check("mis_clear", {63'h0, misalign_err}, 64'h0);
        step(3); out_ready = 1'b0;
        check("drain_f", 64'(exp_q.size()), 64'h0);

        // Async reset mid-stream
        #2; reset = 1'b1; #1;
        check("arst2_valid", {63'h0, out_valid}, 64'h0);
        check("arst2_addr", imem_addr, 64'h0);
        check("arst2_halted", {63'h0, halted}, 64'h0);
`ifdef FETCH_PERF_EN
        check("perf_fetched", {32'h0, perf_fetched}, 64'h0);
        check("perf_stall", {32'h0, perf_stall}, 64'h0);
        check("perf_flush", {32'h0, perf_flush}, 64'h0);
`endif
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
